// File: rtl/axi4_lite_arbiter.sv
`default_nettype none
// ============================================================================
// axi4_lite_arbiter: two AXI4-Lite masters onto one shared slave bus, with
// independent round-robin write and read paths.                    Rev 1.0
// ============================================================================
module axi4_lite_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLAVES = 4,
   parameter int SEL_LSB    = 28
) (
   input  logic                    clk,
   input  logic                    rst,
   // master 0
   input  logic [ADDR_WIDTH-1:0]   m0_awaddr,
   input  logic                    m0_awvalid,
   output logic                    m0_awready,
   input  logic [DATA_WIDTH-1:0]   m0_wdata,
   input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
   input  logic                    m0_wvalid,
   output logic                    m0_wready,
   output logic [1:0]              m0_bresp,
   output logic                    m0_bvalid,
   input  logic                    m0_bready,
   input  logic [ADDR_WIDTH-1:0]   m0_araddr,
   input  logic                    m0_arvalid,
   output logic                    m0_arready,
   output logic [DATA_WIDTH-1:0]   m0_rdata,
   output logic [1:0]              m0_rresp,
   output logic                    m0_rvalid,
   input  logic                    m0_rready,
   // master 1
   input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
   input  logic                    m1_awvalid,
   output logic                    m1_awready,
   input  logic [DATA_WIDTH-1:0]   m1_wdata,
   input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
   input  logic                    m1_wvalid,
   output logic                    m1_wready,
   output logic [1:0]              m1_bresp,
   output logic                    m1_bvalid,
   input  logic                    m1_bready,
   input  logic [ADDR_WIDTH-1:0]   m1_araddr,
   input  logic                    m1_arvalid,
   output logic                    m1_arready,
   output logic [DATA_WIDTH-1:0]   m1_rdata,
   output logic [1:0]              m1_rresp,
   output logic                    m1_rvalid,
   input  logic                    m1_rready,
   // shared slave bus
   output logic [ADDR_WIDTH-1:0]   s_awaddr,
   output logic                    s_awvalid,
   input  logic                    s_awready,
   output logic [DATA_WIDTH-1:0]   s_wdata,
   output logic [DATA_WIDTH/8-1:0] s_wstrb,
   output logic                    s_wvalid,
   input  logic                    s_wready,
   input  logic [1:0]              s_bresp,
   input  logic                    s_bvalid,
   output logic                    s_bready,
   output logic [ADDR_WIDTH-1:0]   s_araddr,
   output logic                    s_arvalid,
   input  logic                    s_arready,
   input  logic [DATA_WIDTH-1:0]   s_rdata,
   input  logic [1:0]              s_rresp,
   input  logic                    s_rvalid,
   output logic                    s_rready,
   output logic [NUM_SLAVES-1:0]   slave_write_sel,
   output logic [NUM_SLAVES-1:0]   slave_read_sel
);

   localparam int         IDX_WIDTH     = ADDR_WIDTH - SEL_LSB;
   localparam logic [1:0] C_RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2, W_ERR = 2'd3} wr_state_e;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2, R_ERR = 2'd3} rd_state_e;

   // An out-of-range index yields an all-zero select, which steers to the error state.
   function automatic logic [NUM_SLAVES-1:0] decode(input logic [IDX_WIDTH-1:0] idx);
      logic [NUM_SLAVES-1:0] sel;
      sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx == IDX_WIDTH'(i)) sel[i] = 1'b1;
      end
      return sel;
   endfunction

   // ---------------------------------------------------------------- write path
   wr_state_e             wr_state_q;
   logic                  wr_gnt_q, wr_last_q, aw_done_q, w_done_q;
   logic [NUM_SLAVES-1:0] wr_sel_q;
   logic                  wr_gnt_d;
   logic [IDX_WIDTH-1:0]  wr_idx;
   logic [NUM_SLAVES-1:0] wr_sel_d;
   logic                  wr_in_addr, wr_in_resp, wr_in_err;
   logic                  g_awvalid, g_wvalid, g_bready;
   logic                  g_awready, g_wready, g_bvalid;
   logic [1:0]            g_bresp;
   logic                  aw_hs, w_hs, b_hs, aw_now, w_now;

   assign wr_gnt_d = (m0_awvalid & m1_awvalid) ? ~wr_last_q : m1_awvalid;
   assign wr_idx   = wr_gnt_d ? m1_awaddr[ADDR_WIDTH-1:SEL_LSB] : m0_awaddr[ADDR_WIDTH-1:SEL_LSB];
   assign wr_sel_d = decode(wr_idx);

   assign wr_in_addr = (wr_state_q == W_ADDR);
   assign wr_in_resp = (wr_state_q == W_RESP);
   assign wr_in_err  = (wr_state_q == W_ERR);

   assign g_awvalid = wr_gnt_q ? m1_awvalid : m0_awvalid;
   assign g_wvalid  = wr_gnt_q ? m1_wvalid  : m0_wvalid;
   assign g_bready  = wr_gnt_q ? m1_bready  : m0_bready;

   assign s_awaddr  = wr_gnt_q ? m1_awaddr : m0_awaddr;
   assign s_wdata   = wr_gnt_q ? m1_wdata  : m0_wdata;
   assign s_wstrb   = wr_gnt_q ? m1_wstrb  : m0_wstrb;
   assign s_awvalid = wr_in_addr & g_awvalid & ~aw_done_q;
   assign s_wvalid  = wr_in_addr & g_wvalid & ~w_done_q;
   assign s_bready  = wr_in_resp & g_bready;

   assign g_awready = ((wr_in_addr & s_awready) | wr_in_err) & ~aw_done_q;
   assign g_wready  = ((wr_in_addr & s_wready)  | wr_in_err) & ~w_done_q;
   assign g_bvalid  = wr_in_resp ? s_bvalid : (wr_in_err & aw_done_q & w_done_q);
   assign g_bresp   = wr_in_err ? C_RESP_DECERR : s_bresp;

   assign aw_hs  = g_awvalid & g_awready;
   assign w_hs   = g_wvalid & g_wready;
   assign b_hs   = g_bvalid & g_bready;
   assign aw_now = aw_done_q | aw_hs;
   assign w_now  = w_done_q | w_hs;

   assign m0_awready = g_awready & ~wr_gnt_q;
   assign m1_awready = g_awready &  wr_gnt_q;
   assign m0_wready  = g_wready  & ~wr_gnt_q;
   assign m1_wready  = g_wready  &  wr_gnt_q;
   assign m0_bvalid  = g_bvalid  & ~wr_gnt_q;
   assign m1_bvalid  = g_bvalid  &  wr_gnt_q;
   assign m0_bresp   = wr_gnt_q ? 2'b00 : g_bresp;
   assign m1_bresp   = wr_gnt_q ? g_bresp : 2'b00;
   assign slave_write_sel = wr_sel_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q <= W_IDLE;
         wr_gnt_q   <= 1'b0;
         wr_last_q  <= 1'b1;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         wr_sel_q   <= '0;
      end else begin
         case (wr_state_q)
            W_IDLE: begin
               if (m0_awvalid | m1_awvalid) begin
                  wr_gnt_q   <= wr_gnt_d;
                  wr_last_q  <= wr_gnt_d;
                  wr_sel_q   <= wr_sel_d;
                  wr_state_q <= (|wr_sel_d) ? W_ADDR : W_ERR;
               end
            end
            W_ADDR: begin
               if (aw_now & w_now) begin
                  wr_state_q <= W_RESP;
                  aw_done_q  <= 1'b0;
                  w_done_q   <= 1'b0;
               end else begin
                  aw_done_q  <= aw_now;
                  w_done_q   <= w_now;
               end
            end
            W_RESP: begin
               if (b_hs) begin
                  wr_state_q <= W_IDLE;
                  wr_sel_q   <= '0;
               end
            end
            W_ERR: begin
               if (b_hs) begin
                  wr_state_q <= W_IDLE;
                  aw_done_q  <= 1'b0;
                  w_done_q   <= 1'b0;
               end else begin
                  aw_done_q  <= aw_now;
                  w_done_q   <= w_now;
               end
            end
            default: wr_state_q <= W_IDLE;
         endcase
      end
   end

   // ----------------------------------------------------------------- read path
   rd_state_e             rd_state_q;
   logic                  rd_gnt_q, rd_last_q, ar_done_q;
   logic [NUM_SLAVES-1:0] rd_sel_q;
   logic                  rd_gnt_d;
   logic [IDX_WIDTH-1:0]  rd_idx;
   logic [NUM_SLAVES-1:0] rd_sel_d;
   logic                  rd_in_addr, rd_in_data, rd_in_err;
   logic                  g_arvalid, g_rready, g_arready, g_rvalid;
   logic [1:0]            g_rresp;
   logic [DATA_WIDTH-1:0] g_rdata;
   logic                  ar_hs, r_hs;

   assign rd_gnt_d = (m0_arvalid & m1_arvalid) ? ~rd_last_q : m1_arvalid;
   assign rd_idx   = rd_gnt_d ? m1_araddr[ADDR_WIDTH-1:SEL_LSB] : m0_araddr[ADDR_WIDTH-1:SEL_LSB];
   assign rd_sel_d = decode(rd_idx);

   assign rd_in_addr = (rd_state_q == R_ADDR);
   assign rd_in_data = (rd_state_q == R_DATA);
   assign rd_in_err  = (rd_state_q == R_ERR);

   assign g_arvalid = rd_gnt_q ? m1_arvalid : m0_arvalid;
   assign g_rready  = rd_gnt_q ? m1_rready  : m0_rready;

   assign s_araddr  = rd_gnt_q ? m1_araddr : m0_araddr;
   assign s_arvalid = rd_in_addr & g_arvalid;
   assign s_rready  = rd_in_data & g_rready;

   // The error responder accepts exactly one address, then answers with DECERR.
   assign g_arready = (rd_in_addr & s_arready) | (rd_in_err & ~ar_done_q);
   assign g_rvalid  = rd_in_data ? s_rvalid : (rd_in_err & ar_done_q);
   assign g_rresp   = rd_in_err ? C_RESP_DECERR : s_rresp;
   assign g_rdata   = rd_in_err ? '0 : s_rdata;

   assign ar_hs = g_arvalid & g_arready;
   assign r_hs  = g_rvalid & g_rready;

   assign m0_arready = g_arready & ~rd_gnt_q;
   assign m1_arready = g_arready &  rd_gnt_q;
   assign m0_rvalid  = g_rvalid  & ~rd_gnt_q;
   assign m1_rvalid  = g_rvalid  &  rd_gnt_q;
   assign m0_rresp   = rd_gnt_q ? 2'b00 : g_rresp;
   assign m1_rresp   = rd_gnt_q ? g_rresp : 2'b00;
   assign m0_rdata   = rd_gnt_q ? '0 : g_rdata;
   assign m1_rdata   = rd_gnt_q ? g_rdata : '0;
   assign slave_read_sel = rd_sel_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_q <= R_IDLE;
         rd_gnt_q   <= 1'b0;
         rd_last_q  <= 1'b1;
         ar_done_q  <= 1'b0;
         rd_sel_q   <= '0;
      end else begin
         case (rd_state_q)
            R_IDLE: begin
               if (m0_arvalid | m1_arvalid) begin
                  rd_gnt_q   <= rd_gnt_d;
                  rd_last_q  <= rd_gnt_d;
                  rd_sel_q   <= rd_sel_d;
                  rd_state_q <= (|rd_sel_d) ? R_ADDR : R_ERR;
               end
            end
            R_ADDR: begin
               if (ar_hs) rd_state_q <= R_DATA;
            end
            R_DATA: begin
               if (r_hs) begin
                  rd_state_q <= R_IDLE;
                  rd_sel_q   <= '0;
               end
            end
            R_ERR: begin
               if (r_hs) begin
                  rd_state_q <= R_IDLE;
                  ar_done_q  <= 1'b0;
               end else if (ar_hs) begin
                  ar_done_q  <= 1'b1;
               end
            end
            default: rd_state_q <= R_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_arbiter.sv
`default_nettype none
// tb_axi4_lite_arbiter: directed scenarios against hand-computed expectations.
`timescale 1ns/1ps
module tb_axi4_lite_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] m0_awaddr, m1_awaddr, m0_araddr, m1_araddr;
   logic        m0_awvalid, m1_awvalid, m0_awready, m1_awready;
   logic [31:0] m0_wdata, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_wvalid, m1_wvalid, m0_wready, m1_wready;
   logic [1:0]  m0_bresp, m1_bresp;
   logic        m0_bvalid, m1_bvalid, m0_bready, m1_bready;
   logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
   logic [31:0] m0_rdata, m1_rdata;
   logic [1:0]  m0_rresp, m1_rresp;
   logic        m0_rvalid, m1_rvalid, m0_rready, m1_rready;
   logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
   logic [3:0]  s_wstrb;
   logic        s_awvalid, s_awready, s_wvalid, s_wready;
   logic [1:0]  s_bresp, s_rresp;
   logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
   logic [3:0]  slave_write_sel, slave_read_sel;

   int n_vec = 0;
   int n_err = 0;

   axi4_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4), .SEL_LSB(28)) dut (
      .clk(clk), .rst(rst),
      .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
      .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
      .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
      .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
      .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
      .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
      .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .slave_write_sel(slave_write_sel), .slave_read_sel(slave_read_sel)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      m0_awaddr = '0; m0_awvalid = 0; m0_wdata = '0; m0_wstrb = '0; m0_wvalid = 0; m0_bready = 0;
      m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
      m1_awaddr = '0; m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0; m1_bready = 0;
      m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
      s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
      s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      m0_awvalid = 1; m0_wvalid = 1; m1_arvalid = 1; s_awready = 1; s_wready = 1; s_arready = 1;
      m0_awaddr = 32'h1000_0000; m1_araddr = 32'h2000_0000;
      tick(); tick(); #1;
      n_vec++; if ({slave_write_sel, slave_read_sel} !== 8'h00) begin n_err++;
         $display("FAIL reset_sel: got %h want 00", {slave_write_sel, slave_read_sel}); end
      n_vec++; if ({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready} !== 5'b0) begin n_err++;
         $display("FAIL reset_s_valid: got %b want 00000", {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}); end
      n_vec++; if ({m0_awready, m0_wready, m1_arready, m0_bvalid, m1_rvalid} !== 5'b0) begin n_err++;
         $display("FAIL reset_m_ready: got %b want 00000", {m0_awready, m0_wready, m1_arready, m0_bvalid, m1_rvalid}); end
      do_reset();
   endtask

   task automatic test_tie();
      do_reset();
      m0_awaddr = 32'h1000_0000; m0_awvalid = 1; m0_wdata = 32'hAAAA_0000; m0_wstrb = 4'hF; m0_wvalid = 1;
      m1_awaddr = 32'h2000_0000; m1_awvalid = 1; m1_wdata = 32'hBBBB_1111; m1_wstrb = 4'h3; m1_wvalid = 1;
      #1;
      n_vec++; if (s_awvalid !== 1'b0) begin n_err++; $display("FAIL tie_idle_awvalid: got %b want 0", s_awvalid); end
      tick(); #1;
      n_vec++; if (slave_write_sel !== 4'b0010) begin n_err++; $display("FAIL tie_sel_m0: got %b want 0010", slave_write_sel); end
      n_vec++; if (s_awaddr !== 32'h1000_0000 || s_wdata !== 32'hAAAA_0000 || s_awvalid !== 1'b1) begin n_err++;
         $display("FAIL tie_fwd_m0: got addr %h data %h v %b want 10000000 aaaa0000 1", s_awaddr, s_wdata, s_awvalid); end
      s_awready = 1; s_wready = 1; #1;
      n_vec++; if ({m1_awready, m0_awready, m1_wready, m0_wready} !== 4'b0101) begin n_err++;
         $display("FAIL tie_ready: got %b want 0101", {m1_awready, m0_awready, m1_wready, m0_wready}); end
      tick();
      m0_awvalid = 0; m0_wvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 1; s_bresp = 2'b00; m0_bready = 1;
      #1;
      n_vec++; if ({m1_bvalid, m0_bvalid, s_bready, s_awvalid} !== 4'b0110) begin n_err++;
         $display("FAIL tie_resp_m0: got %b want 0110", {m1_bvalid, m0_bvalid, s_bready, s_awvalid}); end
      tick();
      s_bvalid = 0; #1;
      n_vec++; if (slave_write_sel !== 4'b0000) begin n_err++; $display("FAIL tie_idle_gap: got %b want 0000", slave_write_sel); end
      tick(); #1;
      n_vec++; if (slave_write_sel !== 4'b0100 || s_awaddr !== 32'h2000_0000 || s_wdata !== 32'hBBBB_1111 || s_wstrb !== 4'h3) begin n_err++;
         $display("FAIL tie_sel_m1: got sel %b addr %h data %h strb %h want 0100 20000000 bbbb1111 3", slave_write_sel, s_awaddr, s_wdata, s_wstrb); end
      s_awready = 1; s_wready = 1;
      tick();
      m1_awvalid = 0; m1_wvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 1; s_bresp = 2'b01; m1_bready = 1;
      #1;
      n_vec++; if ({m1_bvalid, m0_bvalid, m1_bresp} !== 4'b1001) begin n_err++;
         $display("FAIL tie_resp_m1: got %b want 1001", {m1_bvalid, m0_bvalid, m1_bresp}); end
      tick();
      s_bvalid = 0;
   endtask

   task automatic test_fairness();
      int cnt [2];
      int exp_m;
      logic [31:0] exp_addr, got_rdata;
      do_reset();
      cnt[0] = 0; cnt[1] = 0;
      m0_rready = 1; m1_rready = 1; s_arready = 1;
      for (int k = 0; k < 8; k++) begin
         exp_m = k % 2;
         m0_arvalid = (cnt[0] < 4); m0_araddr = 32'h0000_0100 + 32'(cnt[0] * 4);
         m1_arvalid = (cnt[1] < 4); m1_araddr = 32'h3000_0000 + 32'(cnt[1] * 4);
         exp_addr = (exp_m == 1) ? m1_araddr : m0_araddr;
         tick(); #1;
         n_vec++; if ({m1_arready, m0_arready} !== ((exp_m == 1) ? 2'b10 : 2'b01)) begin n_err++;
            $display("FAIL fair_grant_%0d: got %b want m%0d", k, {m1_arready, m0_arready}, exp_m); end
         n_vec++; if (s_araddr !== exp_addr || s_arvalid !== 1'b1) begin n_err++;
            $display("FAIL fair_addr_%0d: got %h v %b want %h 1", k, s_araddr, s_arvalid, exp_addr); end
         n_vec++; if (slave_read_sel !== ((exp_m == 1) ? 4'b1000 : 4'b0001)) begin n_err++;
            $display("FAIL fair_sel_%0d: got %b", k, slave_read_sel); end
         tick();
         cnt[exp_m]++;
         if (exp_m == 1) m1_arvalid = 0; else m0_arvalid = 0;
         s_rvalid = 1; s_rdata = 32'hA000_0000 + 32'(k); s_rresp = 2'b00;
         #1;
         got_rdata = (exp_m == 1) ? m1_rdata : m0_rdata;
         n_vec++; if ({m1_rvalid, m0_rvalid} !== ((exp_m == 1) ? 2'b10 : 2'b01) || got_rdata !== 32'hA000_0000 + 32'(k)) begin n_err++;
            $display("FAIL fair_rdata_%0d: got v %b data %h", k, {m1_rvalid, m0_rvalid}, got_rdata); end
         tick();
         s_rvalid = 0;
      end
   endtask

   task automatic test_skewed_write();
      do_reset();
      m0_awaddr = 32'h1000_0040; m0_awvalid = 1; m0_bready = 1; s_awready = 1; s_wready = 1;
      tick(); #1;
      n_vec++; if ({s_awvalid, s_wvalid, m0_awready} !== 3'b101 || slave_write_sel !== 4'b0010) begin n_err++;
         $display("FAIL skew_aw: got %b sel %b want 101 0010", {s_awvalid, s_wvalid, m0_awready}, slave_write_sel); end
      tick(); #1;
      n_vec++; if ({s_awvalid, m0_awready} !== 2'b00) begin n_err++;
         $display("FAIL skew_aw_drop: got %b want 00", {s_awvalid, m0_awready}); end
      m0_awvalid = 0;
      tick(); tick();
      m0_wvalid = 1; m0_wdata = 32'hCAFE_F00D; m0_wstrb = 4'hC; #1;
      n_vec++; if ({s_wvalid, m0_wready} !== 2'b11 || s_wdata !== 32'hCAFE_F00D || s_wstrb !== 4'hC) begin n_err++;
         $display("FAIL skew_w: got %b data %h strb %h want 11 cafef00d c", {s_wvalid, m0_wready}, s_wdata, s_wstrb); end
      tick(); #1;
      n_vec++; if ({s_wvalid, s_bready, m0_bvalid} !== 3'b010) begin n_err++;
         $display("FAIL skew_resp_state: got %b want 010", {s_wvalid, s_bready, m0_bvalid}); end
      m0_wvalid = 0; s_bvalid = 1; s_bresp = 2'b10; #1;
      n_vec++; if ({m0_bvalid, m0_bresp} !== 3'b110) begin n_err++;
         $display("FAIL skew_bresp: got %b want 110", {m0_bvalid, m0_bresp}); end
      tick();
      s_bvalid = 0; #1;
      n_vec++; if ({s_bready, slave_write_sel} !== 5'b0) begin n_err++;
         $display("FAIL skew_done: got %b want 00000", {s_bready, slave_write_sel}); end
   endtask

   task automatic test_unmapped();
      do_reset();
      m1_araddr = 32'h5000_0000; m1_arvalid = 1; m1_rready = 1; s_arready = 1;
      s_rdata = 32'hDEAD_BEEF; s_rvalid = 1;
      tick(); #1;
      n_vec++; if ({slave_read_sel, s_arvalid, m1_arready, m1_rvalid} !== 7'b0000010) begin n_err++;
         $display("FAIL unmap_rd_addr: got %b want 0000010", {slave_read_sel, s_arvalid, m1_arready, m1_rvalid}); end
      tick();
      m1_arvalid = 0; #1;
      n_vec++; if ({m1_rvalid, m1_rresp, m1_arready, s_rready} !== 5'b11100 || m1_rdata !== 32'h0) begin n_err++;
         $display("FAIL unmap_rd_resp: got %b data %h want 11100 0", {m1_rvalid, m1_rresp, m1_arready, s_rready}, m1_rdata); end
      tick(); #1;
      n_vec++; if (m1_rvalid !== 1'b0) begin n_err++; $display("FAIL unmap_rd_end: got %b want 0", m1_rvalid); end
      s_rvalid = 0;
      m0_awaddr = 32'h4000_0000; m0_awvalid = 1; m0_wvalid = 1; m0_bready = 0; s_awready = 1; s_wready = 1;
      tick(); #1;
      n_vec++; if ({slave_write_sel, s_awvalid, s_wvalid, m0_awready, m0_wready, m0_bvalid} !== 9'b000000110) begin n_err++;
         $display("FAIL unmap_wr_addr: got %b want 000000110", {slave_write_sel, s_awvalid, s_wvalid, m0_awready, m0_wready, m0_bvalid}); end
      tick();
      m0_awvalid = 0; m0_wvalid = 0; #1;
      n_vec++; if ({m0_bvalid, m0_bresp, m0_awready, m0_wready} !== 5'b11100) begin n_err++;
         $display("FAIL unmap_wr_resp: got %b want 11100", {m0_bvalid, m0_bresp, m0_awready, m0_wready}); end
      tick(); #1;
      n_vec++; if (m0_bvalid !== 1'b1) begin n_err++; $display("FAIL unmap_wr_hold: got %b want 1", m0_bvalid); end
      m0_bready = 1;
      tick(); #1;
      n_vec++; if (m0_bvalid !== 1'b0) begin n_err++; $display("FAIL unmap_wr_end: got %b want 0", m0_bvalid); end
   endtask

   task automatic test_concurrent();
      do_reset();
      m0_awaddr = 32'h2000_0008; m0_awvalid = 1; m0_wdata = 32'h1234_5678; m0_wstrb = 4'hF; m0_wvalid = 1; m0_bready = 1;
      m1_araddr = 32'h1000_0004; m1_arvalid = 1; m1_rready = 1;
      s_awready = 1; s_wready = 1; s_arready = 1;
      tick(); #1;
      n_vec++; if (slave_write_sel !== 4'b0100 || slave_read_sel !== 4'b0010) begin n_err++;
         $display("FAIL conc_sel: got w %b r %b want 0100 0010", slave_write_sel, slave_read_sel); end
      n_vec++; if ({s_awvalid, s_arvalid, m0_awready, m1_arready, m1_awready, m0_arready} !== 6'b111100) begin n_err++;
         $display("FAIL conc_valid: got %b want 111100", {s_awvalid, s_arvalid, m0_awready, m1_arready, m1_awready, m0_arready}); end
      n_vec++; if (s_awaddr !== 32'h2000_0008 || s_araddr !== 32'h1000_0004) begin n_err++;
         $display("FAIL conc_addr: got %h %h want 20000008 10000004", s_awaddr, s_araddr); end
      tick();
      m0_awvalid = 0; m0_wvalid = 0; m1_arvalid = 0;
      s_bvalid = 1; s_bresp = 2'b00; s_rvalid = 1; s_rdata = 32'h0BAD_F00D; s_rresp = 2'b00; #1;
      n_vec++; if ({m0_bvalid, m1_rvalid, m1_bvalid, m0_rvalid} !== 4'b1100 || m1_rdata !== 32'h0BAD_F00D) begin n_err++;
         $display("FAIL conc_resp: got %b data %h want 1100 0badf00d", {m0_bvalid, m1_rvalid, m1_bvalid, m0_rvalid}, m1_rdata); end
      tick();
      s_bvalid = 0; s_rvalid = 0; #1;
      n_vec++; if ({slave_write_sel, slave_read_sel} !== 8'h00) begin n_err++;
         $display("FAIL conc_done: got %h want 00", {slave_write_sel, slave_read_sel}); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      m0_awaddr = 32'h3000_0000; m0_awvalid = 1; m0_wvalid = 1; m0_bready = 1; s_awready = 1; s_wready = 1;
      tick(); #1;
      n_vec++; if (slave_write_sel !== 4'b1000) begin n_err++; $display("FAIL rmid_sel: got %b want 1000", slave_write_sel); end
      tick();
      m0_awvalid = 0; m0_wvalid = 0; #1;
      n_vec++; if (s_bready !== 1'b1) begin n_err++; $display("FAIL rmid_in_resp: got %b want 1", s_bready); end
      rst = 1'b1;
      tick();
      rst = 1'b0; s_bvalid = 1; #1;
      n_vec++; if ({slave_write_sel, m0_bvalid, s_bready} !== 6'b0) begin n_err++;
         $display("FAIL rmid_abandon: got %b want 000000", {slave_write_sel, m0_bvalid, s_bready}); end
      s_bvalid = 0;
      m1_awaddr = 32'h0000_0020; m1_awvalid = 1; m1_wvalid = 1; m1_wdata = 32'h5555_AAAA; m1_bready = 1;
      tick(); #1;
      n_vec++; if (slave_write_sel !== 4'b0001 || {m1_awready, m0_awready} !== 2'b10 || s_wdata !== 32'h5555_AAAA) begin n_err++;
         $display("FAIL rmid_new: got sel %b rdy %b data %h want 0001 10 5555aaaa", slave_write_sel, {m1_awready, m0_awready}, s_wdata); end
      tick();
      m1_awvalid = 0; m1_wvalid = 0; s_bvalid = 1; #1;
      n_vec++; if ({m1_bvalid, m0_bvalid} !== 2'b10) begin n_err++; $display("FAIL rmid_new_resp: got %b want 10", {m1_bvalid, m0_bvalid}); end
      tick();
      s_bvalid = 0;
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_tie();
      test_fairness();
      test_skewed_write();
      test_unmapped();
      test_concurrent();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
